// File: rtl/tlk2711_pkg.sv
// Shared TLK2711 link definitions: K-codes, frame header words, RX state
// encoding and status bit positions, used by both the TX and RX blocks.
package tlk2711_pkg;

  localparam logic [7:0] K28_5 = 8'hBC;
  localparam logic [7:0] D5_6  = 8'hC5;
  localparam logic [7:0] K28_2 = 8'h5C;
  localparam logic [7:0] K27_7 = 8'hFB;
  localparam logic [7:0] K29_7 = 8'hFD;
  localparam logic [7:0] K30_7 = 8'hFE;

  localparam logic [7:0] HEAD_0   = 8'hE1;
  localparam logic [7:0] HEAD_1   = 8'h16;
  localparam logic [7:0] HEAD_2   = 8'hEB;
  localparam logic [7:0] HEAD_3   = 8'h90;
  localparam logic [7:0] TX_IND   = 8'h81;
  localparam logic [7:0] FILE_END = 8'h01;

  // 16-bit link words, byte0 in [7:0]
  localparam logic [15:0] COMMA_WORD = {D5_6, K28_5};
  localparam logic [15:0] SOF_WORD   = {K28_2, K27_7};
  localparam logic [15:0] EOF_WORD   = {K29_7, K30_7};
  localparam logic [15:0] HEAD0_WORD = {HEAD_0, HEAD_1};
  localparam logic [15:0] HEAD1_WORD = {HEAD_2, HEAD_3};

  typedef enum logic [3:0] {
    S_IDLE, S_HUNT, S_WAIT_SOF, S_HEAD0, S_HEAD1, S_FSIGN,
    S_FNUM, S_DLEN, S_BODY, S_TAIL, S_EOF, S_DROP
  } rx_state_t;

  localparam int STAT_HDR_ERR   = 0;
  localparam int STAT_K_ERR     = 1;
  localparam int STAT_SEQ_ERR   = 2;
  localparam int STAT_TAIL_ERR  = 3;
  localparam int STAT_OVERFLOW  = 4;
  localparam int STAT_LOST_LOCK = 5;

endpackage

// File: rtl/tlk2711_rx_fifo.sv
// Synchronous first-word-fall-through FIFO; read data is zero while empty.
module tlk2711_rx_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 73
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clear,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_wr;
  logic             w_rd;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_wr    = i_wr_en && !o_full;
  assign w_rd    = i_rd_en && !o_empty;
  assign o_rd_data = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

  // NOTE: storage has no reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/tlk2711_rx_data.sv
// TLK2711 receive framer: comma lock, frame parsing and packing of valid body
// bytes into 64-bit beats for the DMA write path, with sticky error status.
module tlk2711_rx_data
  import tlk2711_pkg::*;
#(
  parameter int DATA_WIDTH  = 64,
  parameter int BODY_WORDS  = 435,
  parameter int LOCK_COMMAS = 16,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_soft_reset,
  input  logic                    i_rx_enable,
  input  logic [15:0]             i_2711_rxd,
  input  logic                    i_2711_rkmsb,
  input  logic                    i_2711_rklsb,
  input  logic                    i_2711_los,
  output logic                    o_dma_wr_valid,
  output logic [DATA_WIDTH-1:0]   o_dma_wr_data,
  output logic [DATA_WIDTH/8-1:0] o_dma_wr_keep,
  output logic                    o_dma_wr_last,
  input  logic                    i_dma_wr_ready,
  output logic                    o_rx_locked,
  output logic [15:0]             o_rx_frame_cnt,
  output logic [5:0]              o_rx_status,
  output logic                    o_rx_interrupt
);

  localparam int KW = DATA_WIDTH / 8;
  localparam int FW = DATA_WIDTH + KW + 1;
  localparam int IW = $clog2(BODY_WORDS + 1);
  localparam int CW = $clog2(LOCK_COMMAS) + 1;
  localparam logic [15:0] MAX_DLEN  = 16'(2 * BODY_WORDS);
  localparam logic [15:0] TAIL_WORD = 16'(2 * (BODY_WORDS + 3));

  logic [15:0]           r_rxd;
  logic                  r_rkmsb, r_rklsb, r_los;
  rx_state_t             r_state;
  logic [CW-1:0]         r_comma_cnt;
  logic                  r_locked;
  logic [15:0]           r_frame_cnt;
  logic [15:0]           r_exp_fnum;
  logic [5:0]            r_status;
  logic                  r_irq;
  logic                  r_frame_err;
  logic                  r_file_end;
  logic [IW-1:0]         r_keep_words;
  logic                  r_dlen_odd;
  logic [IW-1:0]         r_word_idx;
  logic [DATA_WIDTH-1:0] r_pack_data;
  logic [KW-1:0]         r_pack_keep;
  logic                  r_push;
  logic [DATA_WIDTH-1:0] r_push_data;
  logic [KW-1:0]         r_push_keep;
  logic                  r_push_last;

  logic                  w_comma, w_sof, w_eof, w_kword;
  logic                  w_is_kept, w_last_kept;
  logic [1:0]            w_word_keep;
  logic [DATA_WIDTH-1:0] w_merge_data;
  logic [KW-1:0]         w_merge_keep;
  logic                  w_full, w_empty;
  logic [FW-1:0]         w_rd_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rxd   <= '0;
      r_rkmsb <= 1'b0;
      r_rklsb <= 1'b0;
      r_los   <= 1'b0;
    end else if (i_soft_reset) begin
      r_rxd   <= '0;
      r_rkmsb <= 1'b0;
      r_rklsb <= 1'b0;
      r_los   <= 1'b0;
    end else begin
      r_rxd   <= i_2711_rxd;
      r_rkmsb <= i_2711_rkmsb;
      r_rklsb <= i_2711_rklsb;
      r_los   <= i_2711_los;
    end
  end

  assign w_comma = r_rklsb && !r_rkmsb && (r_rxd == COMMA_WORD);
  assign w_sof   = r_rklsb && r_rkmsb && (r_rxd == SOF_WORD);
  assign w_eof   = r_rklsb && r_rkmsb && (r_rxd == EOF_WORD);
  assign w_kword = r_rklsb || r_rkmsb;

  assign w_is_kept   = (r_word_idx < r_keep_words);
  assign w_last_kept = (r_word_idx == r_keep_words - IW'(1));
  assign w_word_keep = (w_last_kept && r_dlen_odd) ? 2'b01 : 2'b11;

  always_comb begin
    // NOTE: defaults first so every path assigns these and no latch is inferred.
    w_merge_data = r_pack_data;
    w_merge_keep = r_pack_keep;
    w_merge_data[{r_word_idx[1:0], 4'b0000} +: 16] = r_rxd;
    w_merge_keep[{r_word_idx[1:0], 1'b0} +: 2]     = w_word_keep;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_comma_cnt  <= '0;
      r_locked     <= 1'b0;
      r_frame_cnt  <= '0;
      r_exp_fnum   <= '0;
      r_status     <= '0;
      r_irq        <= 1'b0;
      r_frame_err  <= 1'b0;
      r_file_end   <= 1'b0;
      r_keep_words <= '0;
      r_dlen_odd   <= 1'b0;
      r_word_idx   <= '0;
      r_pack_data  <= '0;
      r_pack_keep  <= '0;
      r_push       <= 1'b0;
      r_push_data  <= '0;
      r_push_keep  <= '0;
      r_push_last  <= 1'b0;
    end else begin
      r_push <= 1'b0;
      r_irq  <= 1'b0;
      // A dropped beat spoils the frame it belongs to.
      if (r_push && w_full) begin
        r_status[STAT_OVERFLOW] <= 1'b1;
        r_frame_err             <= 1'b1;
      end

      if (i_soft_reset) begin
        r_state     <= S_IDLE;
        r_comma_cnt <= '0;
        r_locked    <= 1'b0;
        r_frame_cnt <= '0;
        r_exp_fnum  <= '0;
        r_status    <= '0;
        r_frame_err <= 1'b0;
        r_file_end  <= 1'b0;
        r_word_idx  <= '0;
        r_pack_data <= '0;
        r_pack_keep <= '0;
      end else if (!i_rx_enable) begin
        r_state     <= S_IDLE;
        r_comma_cnt <= '0;
        r_locked    <= 1'b0;
        r_pack_data <= '0;
        r_pack_keep <= '0;
      end else if (r_los && r_state != S_IDLE) begin
        r_state                  <= S_HUNT;
        r_comma_cnt              <= '0;
        r_locked                 <= 1'b0;
        r_status[STAT_LOST_LOCK] <= 1'b1;
        r_pack_data              <= '0;
        r_pack_keep              <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_state     <= S_HUNT;
            r_comma_cnt <= '0;
          end
          S_HUNT: begin
            if (!w_comma) begin
              r_comma_cnt <= '0;
            end else if (r_comma_cnt == CW'(LOCK_COMMAS - 1)) begin
              r_comma_cnt <= '0;
              r_locked    <= 1'b1;
              r_state     <= S_WAIT_SOF;
            end else begin
              r_comma_cnt <= r_comma_cnt + CW'(1);
            end
          end
          S_WAIT_SOF, S_DROP: begin
            if (w_sof) begin
              r_state     <= S_HEAD0;
              r_frame_err <= 1'b0;
              r_file_end  <= 1'b0;
              r_word_idx  <= '0;
              r_pack_data <= '0;
              r_pack_keep <= '0;
            end else if (r_state == S_DROP) begin
              if (w_eof) r_state <= S_WAIT_SOF;
            end else if (w_kword && !w_comma) begin
              r_status[STAT_K_ERR] <= 1'b1;
            end
          end
          S_HEAD0, S_HEAD1, S_FSIGN, S_FNUM, S_DLEN, S_BODY, S_TAIL: begin
            if (w_kword) begin
              r_status[STAT_K_ERR] <= 1'b1;
              r_state              <= S_DROP;
            end else begin
              case (r_state)
                S_HEAD0: begin
                  if (r_rxd != HEAD0_WORD) begin
                    r_status[STAT_HDR_ERR] <= 1'b1;
                    r_state                <= S_DROP;
                  end else r_state <= S_HEAD1;
                end
                S_HEAD1: begin
                  if (r_rxd != HEAD1_WORD) begin
                    r_status[STAT_HDR_ERR] <= 1'b1;
                    r_state                <= S_DROP;
                  end else r_state <= S_FSIGN;
                end
                S_FSIGN: begin
                  if (r_rxd[7:0] != TX_IND) begin
                    r_status[STAT_HDR_ERR] <= 1'b1;
                    r_state                <= S_DROP;
                  end else begin
                    r_file_end <= (r_rxd[15:8] == FILE_END);
                    r_state    <= S_FNUM;
                  end
                end
                S_FNUM: begin
                  if (r_rxd != r_exp_fnum) begin
                    r_status[STAT_SEQ_ERR] <= 1'b1;
                    r_frame_err            <= 1'b1;
                  end
                  r_exp_fnum <= r_rxd + 16'd1;
                  r_state    <= S_DLEN;
                end
                S_DLEN: begin
                  if (r_rxd > MAX_DLEN) begin
                    r_status[STAT_HDR_ERR] <= 1'b1;
                    r_state                <= S_DROP;
                  end else begin
                    r_keep_words <= IW'(r_rxd >> 1) + IW'(r_rxd[0]);
                    r_dlen_odd   <= r_rxd[0];
                    r_word_idx   <= '0;
                    r_state      <= S_BODY;
                  end
                end
                S_BODY: begin
                  if (w_is_kept) begin
                    if ((&r_word_idx[1:0]) || w_last_kept) begin
                      r_push      <= 1'b1;
                      r_push_data <= w_merge_data;
                      r_push_keep <= w_merge_keep;
                      r_push_last <= w_last_kept;
                      r_pack_data <= '0;
                      r_pack_keep <= '0;
                    end else begin
                      r_pack_data <= w_merge_data;
                      r_pack_keep <= w_merge_keep;
                    end
                  end
                  r_word_idx <= r_word_idx + IW'(1);
                  if (r_word_idx == IW'(BODY_WORDS - 1)) r_state <= S_TAIL;
                end
                default: begin
                  if (r_rxd != TAIL_WORD) begin
                    r_status[STAT_TAIL_ERR] <= 1'b1;
                    r_frame_err             <= 1'b1;
                  end
                  r_state <= S_EOF;
                end
              endcase
            end
          end
          S_EOF: begin
            if (!w_eof) begin
              r_status[STAT_K_ERR] <= 1'b1;
            end else if (!r_frame_err) begin
              r_frame_cnt <= r_frame_cnt + 16'd1;
              if (r_file_end) begin
                r_irq      <= 1'b1;
                r_exp_fnum <= '0;
              end
            end
            r_state <= S_WAIT_SOF;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  tlk2711_rx_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(FW)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clear   (i_soft_reset),
    .i_wr_en   (r_push),
    .i_wr_data ({r_push_data, r_push_keep, r_push_last}),
    .i_rd_en   (o_dma_wr_valid && i_dma_wr_ready),
    .o_rd_data (w_rd_data),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  assign o_dma_wr_valid = !w_empty;
  assign {o_dma_wr_data, o_dma_wr_keep, o_dma_wr_last} = w_rd_data;
  assign o_rx_locked    = r_locked;
  assign o_rx_frame_cnt = r_frame_cnt;
  assign o_rx_status    = r_status;
  assign o_rx_interrupt = r_irq;

endmodule

// File: tb/tb_tlk2711_rx_data.sv
// Self-checking bench for tlk2711_rx_data: expected beats are queued when a
// frame is driven and compared as the DMA side accepts them.
module tb_tlk2711_rx_data;

  localparam int BODY_WORDS = 435;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_soft_reset;
  logic        i_rx_enable;
  logic [15:0] i_2711_rxd;
  logic        i_2711_rkmsb;
  logic        i_2711_rklsb;
  logic        i_2711_los;
  logic        o_dma_wr_valid;
  logic [63:0] o_dma_wr_data;
  logic [7:0]  o_dma_wr_keep;
  logic        o_dma_wr_last;
  logic        i_dma_wr_ready;
  logic        o_rx_locked;
  logic [15:0] o_rx_frame_cnt;
  logic [5:0]  o_rx_status;
  logic        o_rx_interrupt;

  logic [72:0] exp_q [$];
  int n_tests = 0;
  int n_fail = 0;
  int beats_seen = 0;
  int irq_cnt = 0;

  always #5 clk = ~clk;

  tlk2711_rx_data dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_soft_reset   (i_soft_reset),
    .i_rx_enable    (i_rx_enable),
    .i_2711_rxd     (i_2711_rxd),
    .i_2711_rkmsb   (i_2711_rkmsb),
    .i_2711_rklsb   (i_2711_rklsb),
    .i_2711_los     (i_2711_los),
    .o_dma_wr_valid (o_dma_wr_valid),
    .o_dma_wr_data  (o_dma_wr_data),
    .o_dma_wr_keep  (o_dma_wr_keep),
    .o_dma_wr_last  (o_dma_wr_last),
    .i_dma_wr_ready (i_dma_wr_ready),
    .o_rx_locked    (o_rx_locked),
    .o_rx_frame_cnt (o_rx_frame_cnt),
    .o_rx_status    (o_rx_status),
    .o_rx_interrupt (o_rx_interrupt)
  );

  // Scoreboard: every accepted beat is matched against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && o_dma_wr_valid && i_dma_wr_ready) begin
      logic [72:0] exp_beat;
      beats_seen++;
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL beat_unexpected got data=%h keep=%h last=%b", o_dma_wr_data, o_dma_wr_keep, o_dma_wr_last);
      end else begin
        exp_beat = exp_q.pop_front();
        if ({o_dma_wr_data, o_dma_wr_keep, o_dma_wr_last} !== exp_beat)
          begin
            n_fail++;
            $display("FAIL beat got data=%h keep=%h last=%b exp data=%h keep=%h last=%b",
                     o_dma_wr_data, o_dma_wr_keep, o_dma_wr_last, exp_beat[72:9], exp_beat[8:1], exp_beat[0]);
          end
      end
    end
    if (rst_n && o_rx_interrupt) irq_cnt++;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic drive(input logic [15:0] d, input logic km, input logic kl);
    @(posedge clk); #1;
    i_2711_rxd = d; i_2711_rkmsb = km; i_2711_rklsb = kl;
  endtask

  task automatic send_commas(input int n);
    for (int i = 0; i < n; i++) drive(16'hC5BC, 1'b0, 1'b1);
  endtask

  task automatic send_data(input logic [15:0] d);
    drive(d, 1'b0, 1'b0);
  endtask

  // Expected beats for a frame whose body word k is base+k.
  task automatic model_beats(input logic [15:0] dlen, input logic [15:0] base);
    logic [63:0] d;
    logic [7:0]  kp;
    int kw;
    kw = (int'(dlen) + 1) / 2;
    d = '0; kp = '0;
    for (int k = 0; k < kw; k++) begin
      d[16*(k%4) +: 16] = base + 16'(k);
      kp[2*(k%4) +: 2] = (k == kw - 1 && dlen[0]) ? 2'b01 : 2'b11;
      if (k % 4 == 3 || k == kw - 1) begin
        exp_q.push_back({d, kp, (k == kw - 1)});
        d = '0; kp = '0;
      end
    end
  endtask

  task automatic send_frame(input logic [15:0] head0, input logic [15:0] fsign, input logic [15:0] fnum,
                            input logic [15:0] dlen, input logic [15:0] tail, input logic [15:0] base,
                            input bit model);
    if (model) model_beats(dlen, base);
    drive(16'h5CFB, 1'b1, 1'b1);
    send_data(head0);
    send_data(16'hEB90);
    send_data(fsign);
    send_data(fnum);
    send_data(dlen);
    for (int k = 0; k < BODY_WORDS; k++) send_data(base + 16'(k));
    send_data(tail);
    drive(16'hFDFE, 1'b1, 1'b1);
    send_commas(4);
  endtask

  task automatic wait_drain(input string name);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || o_dma_wr_valid) && t < 500) begin
      @(negedge clk);
      t++;
    end
    n_tests++;
    if (t >= 500) begin
      n_fail++;
      $display("FAIL %s drain timeout, %0d beats still expected", name, exp_q.size());
    end
  endtask

  task automatic pulse_soft_reset();
    @(posedge clk); #1; i_soft_reset = 1'b1;
    @(posedge clk); #1; i_soft_reset = 1'b0;
  endtask

  task automatic expect_counts(input string name, input logic [15:0] cnt, input logic [5:0] st);
    @(negedge clk);
    n_tests++;
    if (o_rx_frame_cnt !== cnt) begin
      n_fail++;
      $display("FAIL %s frame_cnt got=%0d exp=%0d", name, o_rx_frame_cnt, cnt);
    end
    n_tests++;
    if (o_rx_status !== st) begin
      n_fail++;
      $display("FAIL %s status got=%h exp=%h", name, o_rx_status, st);
    end
  endtask

  // 15 commas then a data word must not lock; 16 consecutive commas must.
  task automatic lock_boundary(input string name);
    send_commas(15);
    repeat (3) send_data(16'h0000);
    @(negedge clk);
    n_tests++;
    if (o_rx_locked !== 1'b0) begin
      n_fail++;
      $display("FAIL %s locked_after_15 got=%b exp=0", name, o_rx_locked);
    end
    send_commas(18);
    @(negedge clk);
    n_tests++;
    if (o_rx_locked !== 1'b1) begin
      n_fail++;
      $display("FAIL %s locked_after_16 got=%b exp=1", name, o_rx_locked);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; i_soft_reset = 1'b0; i_rx_enable = 1'b0;
    i_2711_rxd = '0; i_2711_rkmsb = 1'b0; i_2711_rklsb = 1'b0; i_2711_los = 1'b0;
    i_dma_wr_ready = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({o_dma_wr_valid, o_dma_wr_data, o_dma_wr_keep, o_dma_wr_last} !== '0) begin
      n_fail++;
      $display("FAIL reset_dma got valid=%b data=%h keep=%h last=%b exp all 0",
               o_dma_wr_valid, o_dma_wr_data, o_dma_wr_keep, o_dma_wr_last);
    end
    n_tests++;
    if ({o_rx_locked, o_rx_interrupt} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_flags got locked=%b irq=%b exp 0", o_rx_locked, o_rx_interrupt);
    end
    expect_counts("reset", 16'd0, 6'h00);
    @(posedge clk); #1;
    rst_n = 1'b1; i_rx_enable = 1'b1;
  endtask

  task automatic test_full_frame();
    int b0;
    b0 = beats_seen;
    send_frame(16'hE116, 16'h0081, 16'd0, 16'd870, 16'h036C, 16'h0000, 1'b1);
    wait_drain("full_frame");
    n_tests++;
    if (beats_seen - b0 !== 109) begin
      n_fail++;
      $display("FAIL full_frame beats got=%0d exp=109", beats_seen - b0);
    end
    expect_counts("full_frame", 16'd1, 6'h00);
  endtask

  task automatic test_sequence();
    int irq0;
    pulse_soft_reset();
    expect_counts("soft_reset", 16'd0, 6'h00);
    n_tests++;
    if (o_rx_locked !== 1'b0) begin
      n_fail++;
      $display("FAIL soft_reset locked got=%b exp=0", o_rx_locked);
    end
    send_commas(20);
    irq0 = irq_cnt;
    send_frame(16'hE116, 16'h0081, 16'd0, 16'd8, 16'h036C, 16'h2000, 1'b1);
    send_frame(16'hE116, 16'h0081, 16'd1, 16'd7, 16'h036C, 16'h3000, 1'b1);
    send_frame(16'hE116, 16'h0181, 16'd3, 16'd3, 16'h036C, 16'h4000, 1'b1);
    wait_drain("sequence");
    expect_counts("sequence", 16'd2, 6'h04);
    n_tests++;
    if (irq_cnt - irq0 !== 0) begin
      n_fail++;
      $display("FAIL sequence irq pulses got=%0d exp=0", irq_cnt - irq0);
    end
    send_frame(16'hE116, 16'h0181, 16'd4, 16'd2, 16'h036C, 16'h4100, 1'b1);
    wait_drain("file_end");
    expect_counts("file_end", 16'd3, 6'h04);
    n_tests++;
    if (irq_cnt - irq0 !== 1) begin
      n_fail++;
      $display("FAIL file_end irq pulses got=%0d exp=1", irq_cnt - irq0);
    end
  endtask

  task automatic test_back_to_back();
    int b0;
    b0 = beats_seen;
    // bytes 0..4 = 10 11 11 11 12; byte 5 is carried but not enabled
    exp_q.push_back({64'h0000_1112_1111_1110, 8'h1F, 1'b1});
    send_frame(16'hE116, 16'h0081, 16'd0, 16'd5, 16'h036C, 16'h1110, 1'b0);
    send_frame(16'hE116, 16'h0081, 16'd1, 16'd0, 16'h036C, 16'h7000, 1'b0);
    wait_drain("back_to_back");
    n_tests++;
    if (beats_seen - b0 !== 1) begin
      n_fail++;
      $display("FAIL back_to_back beats got=%0d exp=1", beats_seen - b0);
    end
    expect_counts("back_to_back", 16'd5, 6'h04);
  endtask

  task automatic test_errors();
    send_frame(16'hE116, 16'h0081, 16'd2, 16'd4, 16'h036A, 16'h5000, 1'b1);
    wait_drain("tail_err");
    expect_counts("tail_err", 16'd5, 6'h0C);
    send_frame(16'hE116, 16'h0081, 16'd3, 16'd9, 16'h036C, 16'h5100, 1'b1);
    wait_drain("after_tail");
    expect_counts("after_tail", 16'd6, 6'h0C);
    send_frame(16'hE117, 16'h0081, 16'd4, 16'd6, 16'h036C, 16'h5200, 1'b0);
    wait_drain("hdr_err");
    expect_counts("hdr_err", 16'd6, 6'h0D);
    send_frame(16'hE116, 16'h0081, 16'd4, 16'd11, 16'h036C, 16'h5300, 1'b1);
    wait_drain("after_hdr");
    expect_counts("after_hdr", 16'd7, 6'h0D);
  endtask

  task automatic test_overflow();
    int b0, t;
    @(posedge clk); #1; i_dma_wr_ready = 1'b0;
    b0 = beats_seen;
    send_frame(16'hE116, 16'h0081, 16'd5, 16'd870, 16'h036C, 16'h6000, 1'b1);
    @(negedge clk);
    n_tests++;
    if (o_rx_status[4] !== 1'b1 || o_dma_wr_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow flags got status=%h valid=%b exp status[4]=1 valid=1", o_rx_status, o_dma_wr_valid);
    end
    @(posedge clk); #1; i_dma_wr_ready = 1'b1;
    t = 0;
    while (o_dma_wr_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    repeat (5) @(negedge clk);
    n_tests++;
    if (beats_seen - b0 !== 16) begin
      n_fail++;
      $display("FAIL overflow delivered got=%0d exp=16", beats_seen - b0);
    end
    exp_q.delete();
    @(negedge clk);
    n_tests++;
    if (o_rx_status !== 6'h1D) begin
      n_fail++;
      $display("FAIL overflow status got=%h exp=1d", o_rx_status);
    end
  endtask

  task automatic test_los();
    int b0;
    pulse_soft_reset();
    send_commas(20);
    b0 = beats_seen;
    exp_q.push_back({64'h8003_8002_8001_8000, 8'hFF, 1'b0});
    exp_q.push_back({64'h8007_8006_8005_8004, 8'hFF, 1'b0});
    drive(16'h5CFB, 1'b1, 1'b1);
    send_data(16'hE116);
    send_data(16'hEB90);
    send_data(16'h0081);
    send_data(16'd0);
    send_data(16'd870);
    for (int k = 0; k < 10; k++) send_data(16'h8000 + 16'(k));
    @(posedge clk); #1;
    i_2711_los = 1'b1; i_2711_rxd = '0; i_2711_rkmsb = 1'b0; i_2711_rklsb = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (o_rx_locked !== 1'b0 || o_rx_status !== 6'h20) begin
      n_fail++;
      $display("FAIL los got locked=%b status=%h exp locked=0 status=20", o_rx_locked, o_rx_status);
    end
    @(posedge clk); #1; i_2711_los = 1'b0;
    lock_boundary("relock");
    wait_drain("los");
    n_tests++;
    if (beats_seen - b0 !== 2) begin
      n_fail++;
      $display("FAIL los beats got=%0d exp=2", beats_seen - b0);
    end
    pulse_soft_reset();
    expect_counts("final_soft_reset", 16'd0, 6'h00);
    n_tests++;
    if (o_rx_locked !== 1'b0 || o_dma_wr_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL final_soft_reset got locked=%b valid=%b exp 0", o_rx_locked, o_dma_wr_valid);
    end
  endtask

  initial begin
    test_reset();
    lock_boundary("lock");
    test_full_frame();
    test_sequence();
    test_back_to_back();
    test_errors();
    test_overflow();
    test_los();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
